// File: rtl/dekatron_step_sequencer_if.sv
// Move-request handshake and Dekatron guide-pulse bundle between a controller
// and the step sequencer.
interface dekatron_step_sequencer_if #(
  parameter int CNT_W = 4
);
  logic             Req;
  logic             Dir;
  logic [CNT_W-1:0] Steps;
  logic             Ack;
  logic             Busy;
  logic             Done;
  logic             PulseRight;
  logic             PulseLeft;
  logic [3:0]       Pos;
  logic             Carry;

  modport master (
    output Req, Dir, Steps,
    input  Ack, Busy, Done, PulseRight, PulseLeft, Pos, Carry
  );

  modport slave (
    input  Req, Dir, Steps,
    output Ack, Busy, Done, PulseRight, PulseLeft, Pos, Carry
  );
endinterface

// File: rtl/dekatron_step_sequencer.sv
// Turns "step N positions forward/reverse" requests into two-phase Dekatron
// guide pulses and tracks the tube's expected decimal position.
module dekatron_step_sequencer #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int CNT_W        = 4
) (
  input logic                      Clk,
  input logic                      Rst,
  dekatron_step_sequencer_if.slave bus
);

  localparam int PH_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0] PULSE_LOAD = PH_W'(PULSE_CYCLES - 1);
  localparam logic [PH_W-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? PH_W'(GAP_CYCLES - 1) : {PH_W{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P1   = 3'd1,
    ST_P2   = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Returns {carry, next_pos}; position always stays within 0..9.
  function automatic logic [4:0] pos_step(input logic [3:0] pos, input logic rev);
    logic [4:0] res;
    if (rev) begin
      if (pos == 4'd0) res = {1'b1, 4'd9};
      else             res = {1'b0, pos - 4'd1};
    end else begin
      if (pos >= 4'd9) res = {1'b1, 4'd0};
      else             res = {1'b0, pos + 4'd1};
    end
    return res;
  endfunction

  state_t           state_r, state_s;
  logic [PH_W-1:0]  phase_r, phase_s;
  logic [CNT_W-1:0] rem_r, rem_s;
  logic             dir_r, dir_s;
  logic [3:0]       pos_r, pos_s;
  logic             carry_r, carry_s;
  logic             ack_r, ack_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             pr_r, pr_s;
  logic             pl_r, pl_s;
  logic [4:0]       step_s;

  // Next-state, counters and next output values; outputs follow the next state.
  always_comb begin
    state_s = state_r;
    phase_s = phase_r;
    rem_s   = rem_r;
    dir_s   = dir_r;
    pos_s   = pos_r;
    carry_s = 1'b0;
    ack_s   = 1'b0;
    step_s  = 5'd0;
    case (state_r)
      ST_IDLE: begin
        if (bus.Req) begin
          ack_s = 1'b1;
          dir_s = bus.Dir;
          rem_s = bus.Steps;
          if (bus.Steps == {CNT_W{1'b0}}) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_P1;
            phase_s = PULSE_LOAD;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_P1: begin
        if (phase_r == {PH_W{1'b0}}) begin
          state_s = ST_P2;
          phase_s = PULSE_LOAD;
        end else begin
          phase_s = phase_r - PH_W'(1);
        end
      end
      ST_P2: begin
        if (phase_r == {PH_W{1'b0}}) begin
          step_s  = pos_step(pos_r, dir_r);
          pos_s   = step_s[3:0];
          carry_s = step_s[4];
          rem_s   = rem_r - CNT_W'(1);
          if (GAP_CYCLES > 0) begin
            state_s = ST_GAP;
            phase_s = GAP_LOAD;
          end else if (rem_s != {CNT_W{1'b0}}) begin
            state_s = ST_P1;
            phase_s = PULSE_LOAD;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          phase_s = phase_r - PH_W'(1);
        end
      end
      ST_GAP: begin
        if (phase_r == {PH_W{1'b0}}) begin
          if (rem_r != {CNT_W{1'b0}}) begin
            state_s = ST_P1;
            phase_s = PULSE_LOAD;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          phase_s = phase_r - PH_W'(1);
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
    done_s = (state_s == ST_DONE);
    // Forward leads with the right guide, reverse with the left.
    pr_s   = ((state_s == ST_P1) && !dir_s) || ((state_s == ST_P2) && dir_s);
    pl_s   = ((state_s == ST_P1) && dir_s)  || ((state_s == ST_P2) && !dir_s);
  end

  // State and registered outputs; reset drops pulses at once and abandons the move.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_r <= ST_IDLE;
      phase_r <= {PH_W{1'b0}};
      rem_r   <= {CNT_W{1'b0}};
      dir_r   <= 1'b0;
      pos_r   <= 4'd0;
      carry_r <= 1'b0;
      ack_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pr_r    <= 1'b0;
      pl_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      phase_r <= phase_s;
      rem_r   <= rem_s;
      dir_r   <= dir_s;
      pos_r   <= pos_s;
      carry_r <= carry_s;
      ack_r   <= ack_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      pr_r    <= pr_s;
      pl_r    <= pl_s;
    end
  end

  assign bus.Ack        = ack_r;
  assign bus.Busy       = busy_r;
  assign bus.Done       = done_r;
  assign bus.PulseRight = pr_r;
  assign bus.PulseLeft  = pl_r;
  assign bus.Pos        = pos_r;
  assign bus.Carry      = carry_r;

endmodule

// File: tb/tb_dekatron_step_sequencer.sv
// Scoreboard bench: per-step expectations are queued when a move is issued and
// popped by a monitor whenever the DUT's Pos changes.
module tb_dekatron_step_sequencer;

  localparam int PULSE = 4;
  localparam int GAP0  = 2;
  localparam int GAP1  = 0;

  typedef struct {
    int pos;
    int carry;
    int lead;
  } step_t;

  logic       Clk;
  logic       Rst;
  logic       req_v;
  logic       dir_v;
  logic [3:0] steps_v;
  logic       sel;
  logic       resync;

  int n_checks;
  int n_fail;
  int model_pos;
  int overlap_cnt;
  int stray_carry;
  step_t exp_q[$];

  dekatron_step_sequencer_if #(.CNT_W(4)) bus0 ();
  dekatron_step_sequencer_if #(.CNT_W(4)) bus1 ();

  dekatron_step_sequencer #(.PULSE_CYCLES(PULSE), .GAP_CYCLES(GAP0), .CNT_W(4)) dut0 (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus0)
  );

  dekatron_step_sequencer #(.PULSE_CYCLES(PULSE), .GAP_CYCLES(GAP1), .CNT_W(4)) dut1 (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus1)
  );

  assign bus0.Req   = req_v & ~sel;
  assign bus0.Dir   = dir_v;
  assign bus0.Steps = steps_v;
  assign bus1.Req   = req_v & sel;
  assign bus1.Dir   = dir_v;
  assign bus1.Steps = steps_v;

  logic       m_ack, m_busy, m_done, m_r, m_l, m_carry;
  logic [3:0] m_pos;
  assign m_ack   = sel ? bus1.Ack        : bus0.Ack;
  assign m_busy  = sel ? bus1.Busy       : bus0.Busy;
  assign m_done  = sel ? bus1.Done       : bus0.Done;
  assign m_r     = sel ? bus1.PulseRight : bus0.PulseRight;
  assign m_l     = sel ? bus1.PulseLeft  : bus0.PulseLeft;
  assign m_carry = sel ? bus1.Carry      : bus0.Carry;
  assign m_pos   = sel ? bus1.Pos        : bus0.Pos;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Step monitor: closes a step when Pos changes, then accumulates this cycle's pulses.
  initial begin
    int    prev_pos;
    int    cnt_r;
    int    cnt_l;
    int    lead;
    step_t e;
    prev_pos = 0; cnt_r = 0; cnt_l = 0; lead = 0;
    forever begin
      @(negedge Clk);
      if (Rst || resync) begin
        prev_pos = int'(m_pos);
        cnt_r = 0; cnt_l = 0; lead = 0;
        resync = 1'b0;
      end else begin
        if (int'(m_pos) != prev_pos) begin
          check_val("step_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val("step_pos", int'(m_pos), e.pos);
            check_val("step_carry", int'(m_carry), e.carry);
            check_val("step_lead", lead, e.lead);
            check_val("step_right_len", cnt_r, PULSE);
            check_val("step_left_len", cnt_l, PULSE);
          end
          cnt_r = 0; cnt_l = 0; lead = 0;
        end else if (m_carry) begin
          stray_carry++;
        end
        if (m_r && m_l) overlap_cnt++;
        if (m_r) begin cnt_r++; if (lead == 0) lead = 1; end
        if (m_l) begin cnt_l++; if (lead == 0) lead = 2; end
        prev_pos = int'(m_pos);
      end
    end
  end

  task automatic run_move(input logic d, input int n, input bit toggle);
    int per, lim, done_c, ack_c, ack_n, r_first, l_first, pos_first, pulse_cyc, busy_bad;
    int p, start;
    per = 2 * PULSE + (sel ? GAP1 : GAP0);
    start = model_pos;
    p = model_pos;
    for (int i = 0; i < n; i++) begin
      step_t e;
      e.carry = d ? int'(p == 0) : int'(p == 9);
      p = d ? (p + 9) % 10 : (p + 1) % 10;
      e.pos = p;
      e.lead = d ? 2 : 1;
      exp_q.push_back(e);
    end
    model_pos = p;
    done_c = 0; ack_c = 0; ack_n = 0; r_first = 0; l_first = 0;
    pos_first = 0; pulse_cyc = 0; busy_bad = 0;
    lim = n * per + 6;
    @(negedge Clk);
    req_v = 1'b1; dir_v = d; steps_v = 4'(n);
    for (int c = 1; c <= lim && done_c == 0; c++) begin
      @(negedge Clk);
      if (c == 1) req_v = 1'b0;
      if (m_ack) begin ack_n++; if (ack_c == 0) ack_c = c; end
      if (m_r && r_first == 0) r_first = c;
      if (m_l && l_first == 0) l_first = c;
      if (m_r || m_l) pulse_cyc++;
      if (int'(m_pos) != start && pos_first == 0) pos_first = c;
      if (!m_busy) busy_bad++;
      if (m_done) done_c = c;
      if (toggle && c >= 2) begin
        req_v   = (c < n * per - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        dir_v   = 1'($urandom_range(0, 1));
        steps_v = 4'($urandom_range(0, 15));
      end
    end
    check_val("ack_cycle", ack_c, 1);
    check_val("ack_count", ack_n, 1);
    check_val("done_cycle", done_c, n * per + 1);
    check_val("busy_while_moving", busy_bad, 0);
    check_val("pulse_cycles", pulse_cyc, n * 2 * PULSE);
    if (n > 0) begin
      check_val("lead_pulse_cycle", d ? l_first : r_first, 1);
      check_val("trail_pulse_cycle", d ? r_first : l_first, PULSE + 1);
      check_val("pos_update_cycle", pos_first, 2 * PULSE + 1);
    end
    req_v = 1'b0;
    @(negedge Clk);
    check_val("busy_after_done", int'(m_busy), 0);
    check_val("pos_final", int'(m_pos), model_pos);
    check_val("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int done_n;
    n_checks = 0; n_fail = 0; overlap_cnt = 0; stray_carry = 0;
    Rst = 1'b1; req_v = 1'b0; dir_v = 1'b0; steps_v = 4'd0;
    sel = 1'b0; resync = 1'b0; model_pos = 0;
    repeat (2) @(negedge Clk);
    check_val("rst_pos", int'(bus0.Pos), 0);
    check_val("rst_busy", int'(bus0.Busy), 0);
    check_val("rst_pulses", int'({bus0.PulseRight, bus0.PulseLeft}), 0);
    check_val("rst_ack_done_carry", int'({bus0.Ack, bus0.Done, bus0.Carry}), 0);
    check_val("rst_pos_dut1", int'(bus1.Pos), 0);
    Rst = 1'b0;

    run_move(1'b0, 1, 1'b0);
    run_move(1'b0, 2, 1'b0);

    // Reset in the middle of P2 of a forward move from Pos=3.
    @(negedge Clk);
    req_v = 1'b1; dir_v = 1'b0; steps_v = 4'd5;
    @(negedge Clk);
    req_v = 1'b0;
    repeat (5) @(negedge Clk);
    check_val("left_before_reset", int'(bus0.PulseLeft), 1);
    check_val("pos_before_reset", int'(bus0.Pos), 3);
    #2 Rst = 1'b1;
    #1;
    check_val("left_at_reset", int'(bus0.PulseLeft), 0);
    check_val("pos_at_reset", int'(bus0.Pos), 0);
    check_val("busy_at_reset", int'(bus0.Busy), 0);
    exp_q.delete();
    model_pos = 0;
    done_n = 0;
    repeat (2) begin @(negedge Clk); if (bus0.Done) done_n++; end
    Rst = 1'b0;
    repeat (12) begin @(negedge Clk); if (bus0.Done) done_n++; end
    check_val("no_done_after_reset", done_n, 0);

    run_move(1'b0, 8, 1'b0);
    run_move(1'b0, 3, 1'b0);
    run_move(1'b1, 2, 1'b0);
    run_move(1'b1, 0, 1'b0);
    run_move(1'b0, 4, 1'b1);

    @(posedge Clk);
    #1;
    sel = 1'b1; resync = 1'b1; model_pos = 0;
    run_move(1'b0, 15, 1'b0);
    run_move(1'b1, 15, 1'b0);

    check_val("overlap_cycles", overlap_cnt, 0);
    check_val("stray_carry", stray_carry, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dekatron_step_sequencer.md
# dekatron_step_sequencer

Clocked driver that sits directly upstream of the Dekatron counter tube model. It turns a "step N positions forward/reverse" request into correctly ordered two-phase guide pulses on PulseRight/PulseLeft. It also keeps a binary shadow of the tube's expected position, with a wrap/borrow flag. Controllers issue moves through a Req/Ack handshake and never drive guide pulses directly.

## Interface
Parameters:
- PULSE_CYCLES, 4: clock cycles each guide pulse stays high; legal range ≥1.
- GAP_CYCLES, 2: idle cycles after each full step before the next one; legal range ≥0 (0 means no GAP state).
- CNT_W, 4: width of Steps and of the internal remaining-steps counter.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- Req  in  1  move request; level, sampled only in IDLE.
- Dir  in  1  direction: 0 = forward (+1 per step), 1 = reverse (−1 per step).
- Steps  in  CNT_W  number of steps to perform; 0 is legal.
- Ack  out  1  one-cycle pulse confirming Dir/Steps were latched.
- Busy  out  1  high whenever state ≠ IDLE.
- Done  out  1  one-cycle pulse when the move is complete.
- PulseRight  out  1  guide pulse to the Dekatron.
- PulseLeft  out  1  guide pulse to the Dekatron.
- Pos  out  4  expected tube position, binary 0..9.
- Carry  out  1  one-cycle pulse on wrap 9→0 (forward) or borrow 0→9 (reverse).

## Operation
- FSM states: IDLE, P1, P2, GAP, DONE. All outputs are registered and decoded from state and registers; there are no combinational paths from inputs to outputs.
- **IDLE:** on a rising edge with Req=1:
  - latch Dir into dir_q and Steps into rem;
  - assert Ack for the next cycle;
  - go to DONE if Steps=0, else go to P1.
- **Req handshake:**
  - The requester must drop Req by the edge ending the Ack cycle.
  - Req, Dir and Steps are ignored outside IDLE.
  - A Req still high on return to IDLE starts a new move (the requester is responsible for avoiding this).
- **Pulse ordering:**
  - Forward: P1 drives PulseRight, P2 drives PulseLeft.
  - Reverse: P1 drives PulseLeft, P2 drives PulseRight.
  - The two pulses never overlap. Both are 0 in IDLE, GAP and DONE.
- **P1 and P2:** each lasts exactly PULSE_CYCLES cycles, tracked by a phase counter reloaded on every state entry.
- **On the edge leaving P2:**
  - Pos updates. Forward: Pos+1, with 9→0 wrapping and setting Carry. Reverse: Pos−1, with 0→9 borrowing and setting Carry.
  - rem decrements by 1.
  - Next state: GAP if GAP_CYCLES>0; else P1 if rem≠0 after the decrement; else DONE.
- **GAP:** lasts GAP_CYCLES cycles, then goes to P1 if rem≠0, else DONE.
- **DONE:** Done=1 for exactly one cycle, then IDLE.
- **Position arithmetic:** Pos never leaves 0..9. The maximum move of 2^CNT_W−1 steps may wrap several times; Carry pulses once per wrap.

## Timing
- **Reset (async, immediate):**
  - state = IDLE;
  - Pos = 0, matching Dekatron reset to cathode 0;
  - PulseRight = PulseLeft = Ack = Busy = Done = Carry = 0;
  - rem = 0.
- **Reset mid-move:** pulses drop in the same instant and the move is abandoned; no Done is issued.
- **Per-step period:** 2·PULSE_CYCLES + GAP_CYCLES cycles.
- **Move latency from the accept edge (edge 0):**
  - Ack is high in cycle 1, together with the first P1 cycle.
  - Done is high in cycle N·(2·PULSE_CYCLES+GAP_CYCLES)+1.
  - IDLE resumes one cycle later.
- **Steps=0:** Ack and Done are both high in cycle 1, with no pulses; IDLE in cycle 2.
- **Pos/Carry timing:** the new Pos and Carry are visible in the first cycle after P2 ends, at the same time as the GAP (or next P1, or DONE) begins.
- **Busy:** high from cycle 1 through the DONE cycle inclusive.

## Test plan
- **Reset:** assert Rst mid-P2 of a forward move with Pos=3. Required: PulseLeft drops immediately; Pos=0, Busy=0, no Done; after release, Req is accepted normally.
- **Single forward step** (PULSE=4, GAP=2), Req, Dir=0, Steps=1 from Pos=0:
  - Ack in cycle 1;
  - PulseRight high cycles 1–4, PulseLeft high cycles 5–8, never overlapping;
  - Pos=1 from cycle 9;
  - Done in cycle 11, Busy low in cycle 12.
- **Forward wrap:** Pos=8, Dir=0, Steps=3. Required: Pos sequence 9, 0, 1; exactly one Carry pulse, coincident with Pos becoming 0; Done after 3 step periods.
- **Reverse borrow:** Pos=1, Dir=1, Steps=2. Required: PulseLeft precedes PulseRight in every step; Pos goes 0 then 9; one Carry pulse at 9.
- **Zero steps and busy requests:**
  - Steps=0: Ack and Done in the same cycle, no pulses, Pos unchanged.
  - Toggling Req/Dir/Steps while Busy: no effect on pulse count or direction.
- **GAP_CYCLES=0, Steps=15:** 30 alternating pulses back-to-back with no idle cycles; Pos advances by 15 mod 10 = 5; Carry pulses equal the number of 9→0 crossings.
